gaussian_blur_3x3: RTL and testbench
====================================

// Module: gaussian_blur_3x3
// PURPOSE
//  Downstream neighbour of the grayscale stage. Consumes the 8-bit grayscale pixel stream, raster order, one byte per GS_valid strobe.
//  Applies a 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 using two W-deep line buffers and a 3x3 window.
//  Emits interior pixels only, (H-2)*(W-2) per frame, with a valid strobe for the second RAM writer.
// PARAMETERS
//  W   320  image width in pixels (>=3)
//  H   480  image height in pixels (>=3)
// PORTS
//  clk       in   1  clock, all state on rising edge
//  rst_n     in   1  asynchronous active-low reset
//  GB_enable in   1  controller enable; level-sensitive, frame runs while high
//  GS_valid  in   1  input pixel strobe, one pixel per high cycle (gaps allowed)
//  Din       in   8  grayscale pixel, sampled when GS_valid=1
//  Dout      out  8  blurred pixel, meaningful only when GB_valid=1, else 8'h00
//  GB_valid  out  1  one-cycle strobe per output pixel
//  GB_busy   out  1  high in FILL/RUN
//  GB_done   out  1  one-cycle pulse after last output of the frame
// BEHAVIOUR
//  Reset: state=IDLE; row/col counters=0; window regs=0; Dout=8'h00, GB_valid=0, GB_busy=0, GB_done=0. Line-buffer contents don't-care.
//  FSM: IDLE -> FILL when GB_enable=1.
//   FILL: accepts pixels until row>=2 && col>=2 (first window complete).
//   FILL -> RUN on the accept that completes the first window.
//   RUN: accepts the remaining pixels. After the accept of pixel (H-1,W-1) -> DONE.
//   DONE: GB_done=1 for exactly one cycle, then IDLE. Re-arms if GB_enable is still high.
//  Accept: GS_valid=1 in FILL/RUN only. GS_valid is ignored in IDLE/DONE; no counter or buffer change.
//  Counters: col 0..W-1 wraps to 0 and increments row; row 0..H-1.
//   Line buffers are written at index col on every accept:
//    lb1[col] <= Din
//    lb0[col] <= old lb1[col]
//  Window: column shift on every accept. New right column = {lb0[col], lb1[col], Din}, top to bottom.
//   Shifted regardless of row, so wrap-around columns enter the window but are never emitted.
//  Emit: on an accept with row>=2 && col>=2, the next cycle has GB_valid=1.
//   Dout = blur of the window centred at (row-1, col-1). Latency exactly 1 clk from the accepting edge.
//   No output for col<2 (row-wrap garbage is suppressed).
//  Arithmetic:
//   sum = p00+2p01+p02+2p10+4p11+2p12+p20+2p21+p22, 12-bit unsigned (max 4080, no overflow).
//   Dout per CONFIGURATION; always <=255, no saturation needed.
//  GB_enable low mid-frame: next edge -> IDLE, counters cleared, GB_valid=0, no GB_done. The frame is abandoned.
//  GB_enable low in DONE: GB_done still pulses.
//  Reset mid-frame: immediate return to reset values; the in-flight output is lost.
//  GS_valid and GB_enable falling in the same cycle: the pixel is not accepted.
//  No back-pressure. The downstream RAM writer must accept every GB_valid strobe.
// CONFIGURATION
//  GB_ROUND_EN defined:   Dout = (sum + 12'd8) >> 4, round-half-up.
//  GB_ROUND_EN undefined: Dout = sum >> 4, truncation.
//  No other behavioural difference; latency identical.
// TESTING (W=4, H=4 unless stated; 4 outputs per frame)
//  1 Constant frame, all pixels 100, GS_valid every cycle
//    -> 4 GB_valid strobes, each Dout=100, then one GB_done pulse.
//  2 Zeros except pixel (1,1)=255
//    -> outputs (1,1),(1,2),(2,1),(2,2) = 64,32,32,16 with GB_ROUND_EN; 63,31,31,15 without.
//  3 Case 1 with GS_valid toggling 1-0-1-0
//    -> same 4 outputs of 100, each 1 clk after its accepting edge, GB_done once.
//  4 Ramp Din=col*16 (0,16,32,48 per row)
//    -> Dout 16,32 per output row. No output at col 0/1; row-wrap never emitted.
//  5 Drop GB_enable after 9 pixels, then re-enable and send full constant 50 frame
//    -> no GB_done for the aborted frame; second frame gives 4x Dout=50 + GB_done.
//  6 Assert rst_n=0 mid-RUN
//    -> all outputs 0 asynchronously; following frame correct as in case 1.

Source files
------------

// File: rtl/gaussian_blur_3x3.sv
// gaussian_blur_3x3: 3x3 Gaussian blur [1 2 1; 2 4 2; 1 2 1]/16 over a raster
// grayscale pixel stream. It uses two W-deep line buffers and a 3x3 window,
// and emits interior pixels only, (H-2)*(W-2) per frame.
// Optional build macro GB_ROUND_EN selects round-half-up. When it is not
// defined, the output is truncated.
module gaussian_blur_3x3 #(
  parameter int W = 320,
  parameter int H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       GB_enable,
  input  logic       GS_valid,
  input  logic [7:0] Din,
  output logic [7:0] Dout,
  output logic       GB_valid,
  output logic       GB_busy,
  output logic       GB_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL2  = CW'(2);
  localparam logic [RW-1:0] ROW2  = RW'(2);
  localparam logic [CW-1:0] COL_L = CW'(W - 1);
  localparam logic [RW-1:0] ROW_L = RW'(H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [7:0]          lb0 [W];
  logic [7:0]          lb1 [W];
  logic [2:0][2:0][7:0] win;   // [row][col], row 0 = top, col 0 = left
  logic [2:0][7:0]     new_col;
  logic                accept;
  logic                win_ok;
  logic                last_px;
  logic [11:0]         sum;
  logic [11:0]         rnd;

  // Pixel acceptance and position qualifiers
  always_comb begin
    accept  = GS_valid && GB_enable && ((state == FILL) || (state == RUN));
    win_ok  = (row >= ROW2) && (col >= COL2);
    last_px = (row == ROW_L) && (col == COL_L);
    new_col = {Din, lb1[col], lb0[col]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nx = state;
    GB_busy  = 1'b0;
    GB_done  = 1'b0;
    unique case (state)
      IDLE: if (GB_enable) state_nx = FILL;
      FILL: begin
        GB_busy = 1'b1;
        // A 3x3 frame finishes on the same accept that completes its first window.
        if (!GB_enable)              state_nx = IDLE;
        else if (accept && last_px)  state_nx = DONE;
        else if (accept && win_ok)   state_nx = RUN;
      end
      RUN: begin
        GB_busy = 1'b1;
        if (!GB_enable)              state_nx = IDLE;
        else if (accept && last_px)  state_nx = DONE;
      end
      DONE: begin
        GB_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Raster position counters; cleared whenever no frame is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if ((state == IDLE) || (state == DONE) || !GB_enable) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_L) begin
        col <= '0;
        row <= (row == ROW_L) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers: lb1 holds the previous row and lb0 holds the row above it
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= Din;
      lb0[col] <= lb1[col];
    end
  end

  // 3x3 window: shift left on every accept, with the new column entering on the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= new_col[r];
      end
    end
  end

  // Kernel sum over the window as it will look after this accept's shift
  always_comb begin
    sum = {4'd0, win[0][1]}        + {3'd0, win[0][2], 1'b0} + {4'd0, new_col[0]}
        + {3'd0, win[1][1], 1'b0}  + {2'd0, win[1][2], 2'b0} + {3'd0, new_col[1], 1'b0}
        + {4'd0, win[2][1]}        + {3'd0, win[2][2], 1'b0} + {4'd0, new_col[2]};
`ifdef GB_ROUND_EN
    rnd = sum + 12'd8;
`else
    rnd = sum;
`endif
  end

  // Output register: one strobe per interior pixel, one clock after its accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GB_valid <= 1'b0;
      Dout     <= '0;
    end else if (accept && win_ok) begin
      GB_valid <= 1'b1;
      Dout     <= rnd[11:4];
    end else begin
      GB_valid <= 1'b0;
      Dout     <= '0;
    end
  end

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Self-checking bench for gaussian_blur_3x3 with W=4, H=4. It drives
// frames and compares the results against a kernel model that works
// on whole images.
module tb_gaussian_blur_3x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       GB_enable = 1'b0;
  logic       GS_valid = 1'b0;
  logic [7:0] Din = '0;
  logic [7:0] Dout;
  logic       GB_valid, GB_busy, GB_done;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] img [4][4];
  logic       got_v [16];
  logic [7:0] got_d [16];
  int         vcnt = 0;
  int         dcnt = 0;
  int         done_at_v = 0;

  gaussian_blur_3x3 #(.W(4), .H(4)) dut (
    .clk(clk), .rst_n(rst_n), .GB_enable(GB_enable), .GS_valid(GS_valid),
    .Din(Din), .Dout(Dout), .GB_valid(GB_valid), .GB_busy(GB_busy), .GB_done(GB_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (GB_valid) vcnt = vcnt + 1;
    if (GB_done) begin
      dcnt = dcnt + 1;
      done_at_v = vcnt;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: kernel-weighted sum of the image around (r-1,c-1), then divided by 16
  function automatic int model(input int r, input int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += int'(img[r-1+dr][c-1+dc]) * (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc));
`ifdef GB_ROUND_EN
    s += 8;
`endif
    return s / 16;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = v;
  endtask

  task automatic drive_frame(input int gmin, input int gmax, input int npix);
    int g;
    @(negedge clk);
    GB_enable = 1'b1;
    GS_valid  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < npix; i++) begin
      GS_valid = 1'b1;
      Din = img[i/4][i%4];
      @(posedge clk);
      #1;
      got_v[i] = GB_valid;
      got_d[i] = Dout;
      @(negedge clk);
      GS_valid = 1'b0;
      Din = 8'($urandom);
      g = int'($urandom_range(gmax, gmin));
      repeat (g) @(negedge clk);
    end
    GB_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; GS_valid = 1'b1; GB_enable = 1'b0; Din = 8'hA5;
    repeat (2) @(negedge clk);
    compared++; if (Dout !== 8'h00)  begin mismatched++; $display("FAIL reset_dout: got %h want 00", Dout); end
    compared++; if (GB_valid !== 0)  begin mismatched++; $display("FAIL reset_valid: got %b want 0", GB_valid); end
    compared++; if (GB_busy !== 0)   begin mismatched++; $display("FAIL reset_busy: got %b want 0", GB_busy); end
    compared++; if (GB_done !== 0)   begin mismatched++; $display("FAIL reset_done: got %b want 0", GB_done); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compared++; if (GB_busy !== 0 || GB_valid !== 0)
      begin mismatched++; $display("FAIL idle_ignore: got busy=%b valid=%b want 0/0", GB_busy, GB_valid); end
    GS_valid = 1'b0;
  endtask

  task automatic test_constant;
    int v0 = vcnt, d0 = dcnt;
    fill_const(8'd100);
    drive_frame(0, 0, 16);
    for (int i = 0; i < 16; i++) begin
      logic ev = (i/4 >= 2) && (i%4 >= 2);
      compared++;
      if (got_v[i] !== ev) begin mismatched++; $display("FAIL const_valid px%0d: got %b want %b", i, got_v[i], ev); end
      compared++;
      if (got_d[i] !== (ev ? 8'd100 : 8'd0)) begin mismatched++; $display("FAIL const_dout px%0d: got %0d want %0d", i, got_d[i], ev ? 100 : 0); end
    end
    compared++; if (vcnt - v0 !== 4) begin mismatched++; $display("FAIL const_strobes: got %0d want 4", vcnt - v0); end
    compared++; if (dcnt - d0 !== 1) begin mismatched++; $display("FAIL const_done: got %0d want 1", dcnt - d0); end
    compared++; if (done_at_v - v0 !== 4) begin mismatched++; $display("FAIL const_done_order: got %0d outputs before done want 4", done_at_v - v0); end
  endtask

  task automatic test_impulse;
    int idx [4] = '{10, 11, 14, 15};
`ifdef GB_ROUND_EN
    int want [4] = '{64, 32, 32, 16};
`else
    int want [4] = '{63, 31, 31, 15};
`endif
    fill_const(8'd0);
    img[1][1] = 8'd255;
    drive_frame(0, 0, 16);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (got_v[idx[k]] !== 1'b1 || int'(got_d[idx[k]]) !== want[k])
        begin mismatched++; $display("FAIL impulse px%0d: got v=%b d=%0d want v=1 d=%0d", idx[k], got_v[idx[k]], got_d[idx[k]], want[k]); end
    end
  endtask

  task automatic test_toggle;
    int v0 = vcnt, d0 = dcnt;
    fill_const(8'd100);
    drive_frame(1, 1, 16);
    for (int i = 0; i < 16; i++) begin
      logic ev = (i/4 >= 2) && (i%4 >= 2);
      compared++;
      if (got_v[i] !== ev || (ev && got_d[i] !== 8'd100))
        begin mismatched++; $display("FAIL toggle px%0d: got v=%b d=%0d want v=%b d=100", i, got_v[i], got_d[i], ev); end
    end
    compared++; if (vcnt - v0 !== 4) begin mismatched++; $display("FAIL toggle_strobes: got %0d want 4", vcnt - v0); end
    compared++; if (dcnt - d0 !== 1) begin mismatched++; $display("FAIL toggle_done: got %0d want 1", dcnt - d0); end
  endtask

  task automatic test_ramp;
    int v0 = vcnt;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 8'(c * 16);
    drive_frame(0, 0, 16);
    for (int i = 0; i < 16; i++) begin
      logic ev = (i/4 >= 2) && (i%4 >= 2);
      compared++;
      if (got_v[i] !== ev || (ev && int'(got_d[i]) !== model(i/4, i%4)))
        begin mismatched++; $display("FAIL ramp px%0d: got v=%b d=%0d want v=%b d=%0d", i, got_v[i], got_d[i], ev, ev ? model(i/4, i%4) : 0); end
    end
    compared++; if (vcnt - v0 !== 4) begin mismatched++; $display("FAIL ramp_strobes: got %0d want 4", vcnt - v0); end
  endtask

  task automatic test_abort;
    int v0 = vcnt, d0 = dcnt;
    fill_const(8'd77);
    drive_frame(0, 0, 9);
    compared++; if (GB_busy !== 0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", GB_busy); end
    compared++; if (dcnt - d0 !== 0) begin mismatched++; $display("FAIL abort_done: got %0d want 0", dcnt - d0); end
    compared++; if (vcnt - v0 !== 0) begin mismatched++; $display("FAIL abort_strobes: got %0d want 0", vcnt - v0); end
    v0 = vcnt; d0 = dcnt;
    fill_const(8'd50);
    drive_frame(0, 0, 16);
    for (int i = 10; i < 16; i++) begin
      if ((i%4) >= 2) begin
        compared++;
        if (got_v[i] !== 1'b1 || got_d[i] !== 8'd50)
          begin mismatched++; $display("FAIL rearm px%0d: got v=%b d=%0d want v=1 d=50", i, got_v[i], got_d[i]); end
      end
    end
    compared++; if (vcnt - v0 !== 4 || dcnt - d0 !== 1)
      begin mismatched++; $display("FAIL rearm_counts: got %0d strobes %0d done want 4 1", vcnt - v0, dcnt - d0); end
  endtask

  task automatic test_reset_mid;
    int v0, d0;
    fill_const(8'd100);
    @(negedge clk); GB_enable = 1'b1; GS_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      GS_valid = 1'b1; Din = img[i/4][i%4];
      @(negedge clk);
    end
    compared++; if (GB_valid !== 1'b1 || GB_busy !== 1'b1)
      begin mismatched++; $display("FAIL midrun_state: got valid=%b busy=%b want 1/1", GB_valid, GB_busy); end
    #1 rst_n = 1'b0;
    #1;
    compared++; if (GB_valid !== 0 || Dout !== 8'h00 || GB_busy !== 0 || GB_done !== 0)
      begin mismatched++; $display("FAIL async_reset: got v=%b d=%h busy=%b done=%b want all 0", GB_valid, Dout, GB_busy, GB_done); end
    GS_valid = 1'b0; GB_enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    v0 = vcnt; d0 = dcnt;
    drive_frame(0, 0, 16);
    for (int i = 0; i < 16; i++) begin
      logic ev = (i/4 >= 2) && (i%4 >= 2);
      compared++;
      if (got_v[i] !== ev || (ev && got_d[i] !== 8'd100))
        begin mismatched++; $display("FAIL post_reset px%0d: got v=%b d=%0d want v=%b d=100", i, got_v[i], got_d[i], ev); end
    end
    compared++; if (vcnt - v0 !== 4 || dcnt - d0 !== 1)
      begin mismatched++; $display("FAIL post_reset_counts: got %0d strobes %0d done want 4 1", vcnt - v0, dcnt - d0); end
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      int v0 = vcnt, d0 = dcnt;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 8'($urandom);
      drive_frame(0, 2, 16);
      for (int i = 0; i < 16; i++) begin
        logic ev = (i/4 >= 2) && (i%4 >= 2);
        compared++;
        if (got_v[i] !== ev || (ev && int'(got_d[i]) !== model(i/4, i%4)))
          begin mismatched++; $display("FAIL random f%0d px%0d: got v=%b d=%0d want v=%b d=%0d", f, i, got_v[i], got_d[i], ev, ev ? model(i/4, i%4) : 0); end
      end
      compared++; if (vcnt - v0 !== 4 || dcnt - d0 !== 1)
        begin mismatched++; $display("FAIL random_counts f%0d: got %0d strobes %0d done want 4 1", f, vcnt - v0, dcnt - d0); end
    end
  endtask

  initial begin
    test_reset;
    test_constant;
    test_impulse;
    test_toggle;
    test_ramp;
    test_abort;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
